lif_accumulator: RTL
====================

// Module: lif_accumulator
// PURPOSE
//  Per-timestep leaky integrate stage that sits directly upstream of the lateral-inhibition (LI) block.
//  Each step it sums weighted input spikes into N neuron potentials, applies leak, then pulses start_li.
//  It waits for the LI verdict and performs the winner-take-all reset on the potentials it drives.
// PARAMETERS
//  N      8   number of output neurons
//  W      24  potential width (unsigned, saturating)
//  M      16  number of input spike lines
//  WW     8   weight width (unsigned); one weight word = N*WW bits, neuron k at [k*WW +: WW]
//  LEAK   1   per-step leak subtracted from every potential
//  REF_T  4   refractory length in steps (used only with LIF_REFRACTORY_EN)
// PORTS
//  clk         in   1      clock; all logic on posedge
//  rst         in   1      reset, synchronous, active-low
//  step_start  in   1      pulse: begin one timestep; spikes_in sampled this cycle
//  spikes_in   in   M      input spike vector for the step
//  w_addr      out  log2M  weight RAM read address (synchronous RAM, 1-cycle read latency)
//  w_data      in   N*WW   weight word for address presented on previous cycle
//  potentials  out  N*W    neuron k at [k*W +: W]; feeds LI
//  start_li    out  1      1-cycle pulse to LI
//  valid_li    in   1      LI verdict strobe
//  won_lost    in   N      LI verdict; one-hot winner when first_spike=1
//  first_spike in   1      qualifies won_lost
//  spike_out   out  N      registered one-hot winner, valid with step_done
//  step_done   out  1      1-cycle pulse: step complete
//  busy        out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE; potentials, spike_out, w_addr=0; start_li, step_done, busy=0.
//  States: IDLE -> ACCUM -> LEAK -> START -> WAIT_LI -> UPDATE -> IDLE.
//  IDLE: on step_start latch spikes_in into spk_r, set cnt=0, go ACCUM. step_start while busy is ignored.
//  ACCUM: M+1 cycles, cnt=0..M. When cnt<M, w_addr=cnt. When cnt>=1 and spk_r[cnt-1]=1,
//    pot[k] += w_data[k] for all k. Add is W+1 bits, saturating at 2^W-1. At cnt==M go LEAK.
//  LEAK (1 cycle): pot[k] = (pot[k] > LEAK) ? pot[k]-LEAK : 0.
//  START (1 cycle): start_li=1; go WAIT_LI.
//  WAIT_LI: hold potentials stable; no timeout. On valid_li:
//    - first_spike=1: latch spike_out=won_lost; clear every pot[k] to 0 (global inhibition).
//    - first_spike=0: spike_out=0; potentials unchanged; won_lost is ignored.
//    Go UPDATE.
//  UPDATE (1 cycle): step_done=1; go IDLE.
//  valid_li outside WAIT_LI is ignored.
//  Step latency with LI immediate: M+4 cycles from step_start to step_done, plus the LI wait.
//  spike_out holds its value until the next verdict or reset.
//  Reset mid-step aborts the step and clears all state; a pending LI verdict is dropped.
//  Illegal state: go IDLE with potentials preserved.
// CONFIGURATION
//  LIF_REFRACTORY_EN defined:
//    - Per-neuron counter ref[k] (width ceil(log2(REF_T+1))).
//    - The winner loads ref=REF_T on a first_spike verdict.
//    - While ref[k]!=0, ACCUM adds nothing to pot[k], and LEAK decrements ref[k].
//  Not defined: no counters; every neuron integrates every step.
// TESTING
//  1. rst=0 for 2 cycles mid-ACCUM -> potentials=0, busy=0, state IDLE next cycle.
//  2. spikes_in=16'h0001, all weights=10, LEAK=1 -> after LEAK all pot=9;
//     start_li pulses at cycle M+2 after step_start.
//  3. Sat: all spikes, weights=8'hFF, pot preloaded near 2^24-1 -> pot clamps at 24'hFFFFFF, no wrap.
//  4. valid_li with first_spike=1, won_lost=8'b0000_0100 -> spike_out=8'h04, all pot=0, step_done 1 cycle later.
//  5. first_spike=0 verdict -> spike_out=0, potentials kept; step_start during busy ignored.
//  6. LIF_REFRACTORY_EN: neuron 2 wins -> pot[2] stays 0 for 4 steps with spikes applied, then integrates.

Source files
------------

// File: rtl/lif_accumulator.sv
// lif_accumulator: per-timestep leaky integrate stage feeding lateral inhibition.
// Each step sums weighted input spikes into N neuron potentials, applies a
// fixed leak, pulses start_li, waits for the LI verdict and applies the
// winner-take-all reset.
//
// Ports:
//   clk, rst          clock (posedge) / synchronous active-low reset
//   step_start        begin a timestep; spikes_in sampled the same cycle
//   spikes_in [M]     input spike vector for the step
//   w_addr            weight RAM read address (RAM has 1-cycle read latency)
//   w_data [N*WW]     weight word for the address of the previous cycle
//   potentials [N*W]  neuron k at [k*W +: W]
//   start_li          1-cycle pulse to LI
//   valid_li          LI verdict strobe; won_lost/first_spike qualify it
//   spike_out [N]     registered winner vector, valid with step_done
//   step_done         1-cycle pulse at the end of the step
//   busy              high whenever not IDLE
//
// Optional feature: define LIF_REFRACTORY_EN to give each neuron a refractory
// counter of REF_T steps after it wins.

module lif_lane #(
  parameter int W     = 24,
  parameter int WW    = 8,
  parameter int LEAK  = 1,
  parameter int REF_T = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          add_en,
  input  logic          leak_en,
  input  logic          clr,
  input  logic          win,
  input  logic [WW-1:0] w,
  output logic [W-1:0]  pot
);
  logic         integ_ok;
  logic [W:0]   sum;

  // One extra bit catches the carry so the add can clamp instead of wrap.
  assign sum = {1'b0, pot} + {{(W+1-WW){1'b0}}, w};

`ifdef LIF_REFRACTORY_EN
  localparam int RW = $clog2(REF_T + 1);
  logic [RW-1:0] rfr;

  always_ff @(posedge clk) begin
    if (!rst)                       rfr <= '0;
    else if (clr && win)            rfr <= RW'(REF_T);
    else if (leak_en && rfr != '0)  rfr <= rfr - RW'(1);
  end

  assign integ_ok = (rfr == '0);
`else
  logic unused_win;
  assign unused_win = win;
  assign integ_ok   = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst)                     pot <= '0;
    else if (clr)                 pot <= '0;
    else if (add_en && integ_ok)  pot <= sum[W] ? '1 : sum[W-1:0];
    else if (leak_en)             pot <= (pot > W'(LEAK)) ? pot - W'(LEAK) : '0;
  end
endmodule

module lif_accumulator #(
  parameter int N     = 8,
  parameter int W     = 24,
  parameter int M     = 16,
  parameter int WW    = 8,
  parameter int LEAK  = 1,
  parameter int REF_T = 4,
  localparam int AW   = (M > 1) ? $clog2(M) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            step_start,
  input  logic [M-1:0]    spikes_in,
  output logic [AW-1:0]   w_addr,
  input  logic [N*WW-1:0] w_data,
  output logic [N*W-1:0]  potentials,
  output logic            start_li,
  input  logic            valid_li,
  input  logic [N-1:0]    won_lost,
  input  logic            first_spike,
  output logic [N-1:0]    spike_out,
  output logic            step_done,
  output logic            busy
);
  localparam int CW = $clog2(M + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCUM, S_LEAK, S_START, S_WAIT, S_UPDATE
  } state_t;

  state_t state, state_nx;
  logic [M-1:0]           spk_r;
  logic [CW-1:0]          cnt;
  logic [AW-1:0]          idx;
  logic                   add_en, leak_en, verdict, clr;
  logic [N-1:0][WW-1:0]   w_a;
  logic [N-1:0][W-1:0]    pot_a;

  assign w_a        = w_data;
  assign potentials = pot_a;

  // w_data in the cnt cycle belongs to address cnt-1 (one-cycle RAM latency).
  assign idx     = AW'(cnt - CW'(1));
  assign add_en  = (state == S_ACCUM) && (cnt != '0) && spk_r[idx];
  assign leak_en = (state == S_LEAK);
  assign verdict = (state == S_WAIT) && valid_li;
  assign clr     = verdict && first_spike;

  assign w_addr    = (state == S_ACCUM && cnt < CW'(M)) ? AW'(cnt) : '0;
  assign start_li  = (state == S_START);
  assign step_done = (state == S_UPDATE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      spk_r     <= '0;
      cnt       <= '0;
      spike_out <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && step_start) begin
        spk_r <= spikes_in;
        cnt   <= '0;
      end else if (state == S_ACCUM) begin
        cnt <= cnt + CW'(1);
      end
      if (verdict) spike_out <= first_spike ? won_lost : '0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (step_start) state_nx = S_ACCUM;
      S_ACCUM:  if (cnt == CW'(M)) state_nx = S_LEAK;
      S_LEAK:   state_nx = S_START;
      S_START:  state_nx = S_WAIT;
      S_WAIT:   if (valid_li) state_nx = S_UPDATE;
      S_UPDATE: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    lif_lane #(.W(W), .WW(WW), .LEAK(LEAK), .REF_T(REF_T)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .add_en  (add_en),
      .leak_en (leak_en),
      .clr     (clr),
      .win     (won_lost[k]),
      .w       (w_a[k]),
      .pot     (pot_a[k])
    );
  end
endmodule
